exp4_trena: RTL and testbench

- Ultrasonic tape-measure top level for the HC-SR04 sensor.
- On a `mensurar` request it fires a 10 µs trigger, times the echo pulse and converts it to centimetres (3 BCD digits, rounded to nearest).
- Shows the result on three 7-segment displays.
- Transmits the result serially as ASCII `"DDD#"`, then pulses `pronto`.

---
 rtl/trena_pkg.sv | 64 ++++++
 rtl/tx_serial_7e2.sv | 45 ++++
 rtl/exp4_trena.sv | 152 +++++++++++++++
 tb/tb_exp4_trena.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/trena_pkg.sv
// Shared definitions for the ultrasonic tape measure: state codes, default
// timing, ASCII constants and the BCD / 7-segment helpers.
package trena_pkg;

  typedef enum logic [3:0] {
    INICIAL       = 4'h0,
    PREPARACAO    = 4'h1,
    ENVIA_TRIGGER = 4'h2,
    ESPERA_ECHO   = 4'h3,
    MEDIDA        = 4'h4,
    ARMAZENA      = 4'h5,
    TRANSMITE     = 4'h6,
    FINAL         = 4'h7,
    TIMEOUT       = 4'hE
  } estado_t;

  localparam int CLK_HZ_DEF         = 50_000_000;
  localparam int CICLOS_CM_DEF      = 2941;
  localparam int CICLOS_TRIGGER_DEF = 500;
  localparam int CICLOS_BIT_DEF     = 434;
  localparam int CICLOS_TIMEOUT_DEF = 3_000_000;

  localparam logic [6:0]  ASCII_0    = 7'h30;
  localparam logic [6:0]  ASCII_HASH = 7'h23;
  localparam logic [11:0] BCD_MAX    = 12'h999;

  // Active-low segments, bit 6 = g ... bit 0 = a.
  function automatic logic [6:0] hex7seg(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // Three-digit BCD increment that sticks at 999.
  function automatic logic [11:0] bcd_inc(input logic [11:0] b);
    logic [3:0] d0, d1, d2;
    {d2, d1, d0} = b;
    if (b == BCD_MAX) return b;
    if (d0 == 4'd9) begin
      d0 = 4'd0;
      if (d1 == 4'd9) begin
        d1 = 4'd0;
        d2 = d2 + 4'd1;
      end else d1 = d1 + 4'd1;
    end else d0 = d0 + 4'd1;
    return {d2, d1, d0};
  endfunction

endpackage

// File: rtl/tx_serial_7e2.sv
// UART transmitter, 7 data bits LSB first, even parity, 2 stop bits.
// A new partida is accepted in the last cycle of the final stop bit, so frames chain without gaps.
module tx_serial_7e2 #(
  parameter int CICLOS_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] dado,
  input  logic       partida,
  output logic       saida_serial,
  output logic       pronto_tx
);
  localparam int BW = (CICLOS_BIT > 1) ? $clog2(CICLOS_BIT) : 1;

  logic          ocupado;
  logic [10:0]   sr;
  logic [BW-1:0] cnt;
  logic [3:0]    nbit;
  logic          fim_bit;

  assign fim_bit      = (cnt == BW'(CICLOS_BIT - 1));
  assign pronto_tx    = ocupado & fim_bit & (nbit == 4'd10);
  assign saida_serial = ocupado ? sr[0] : 1'b1;

  always_ff @(posedge clock) begin
    if (!reset) begin
      ocupado <= 1'b0;
      sr      <= '1;
      cnt     <= '0;
      nbit    <= '0;
    end else if (partida && (!ocupado || pronto_tx)) begin
      ocupado <= 1'b1;
      sr      <= {2'b11, ^dado, dado, 1'b0};
      cnt     <= '0;
      nbit    <= '0;
    end else if (ocupado) begin
      if (fim_bit) begin
        cnt <= '0;
        sr  <= {1'b1, sr[10:1]};
        if (nbit == 4'd10) ocupado <= 1'b0;
        else               nbit    <= nbit + 4'd1;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/exp4_trena.sv
// HC-SR04 tape measure: trigger, echo timing in BCD centimetres with rounding,
// 7-segment display and serial report "DDD#".
module exp4_trena
  import trena_pkg::*;
#(
  parameter int CLK_HZ         = CLK_HZ_DEF,
  parameter int CICLOS_CM      = CLK_HZ / 17_000,
  parameter int CICLOS_TRIGGER = CLK_HZ / 100_000,
  parameter int CICLOS_BIT     = CLK_HZ / 115_200,
  parameter int CICLOS_TIMEOUT = CLK_HZ / 1000 * 60
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mensurar,
  input  logic       echo,
  output logic       trigger,
  output logic       saida_serial,
  output logic       pronto,
  output logic [6:0] medida0,
  output logic [6:0] medida1,
  output logic [6:0] medida2,
  output logic [6:0] db_estado,
  output logic       db_echo,
  output logic       db_mensurar,
  output logic       db_trigger,
  output logic       db_saida_serial
);
  localparam int TW = $clog2(CICLOS_TIMEOUT + 1);
  localparam int CW = $clog2(CICLOS_CM);

  estado_t       estado, proximo;
  logic          echo_m, echo_s, mensurar_d, borda;
  logic [TW-1:0] tempo;
  logic [CW-1:0] cnt_cm;
  logic [11:0]   bcd, medida_reg;
  logic [1:0]    idx, sel;
  logic          inicio_tx, partida, pronto_tx;
  logic [6:0]    dado;

  assign borda = mensurar & ~mensurar_d;

  always_ff @(posedge clock) begin
    if (!reset) estado <= INICIAL;
    else        estado <= proximo;
  end

  always_comb begin
    proximo = estado;
    trigger = 1'b0;
    pronto  = 1'b0;
    partida = 1'b0;
    case (estado)
      INICIAL:       if (borda) proximo = PREPARACAO;
      PREPARACAO:    proximo = ENVIA_TRIGGER;
      ENVIA_TRIGGER: begin
        trigger = 1'b1;
        if (tempo == TW'(CICLOS_TRIGGER - 1)) proximo = ESPERA_ECHO;
      end
      ESPERA_ECHO:
        if (echo_s)                                proximo = MEDIDA;
        else if (tempo == TW'(CICLOS_TIMEOUT - 1)) proximo = TIMEOUT;
      MEDIDA:
        if (!echo_s)                               proximo = ARMAZENA;
        else if (tempo == TW'(CICLOS_TIMEOUT - 1)) proximo = TIMEOUT;
      TIMEOUT:       proximo = ARMAZENA;
      ARMAZENA:      proximo = TRANSMITE;
      TRANSMITE: begin
        partida = inicio_tx | (pronto_tx & (idx != 2'd3));
        if (pronto_tx && idx == 2'd3) proximo = FINAL;
      end
      FINAL: begin
        pronto  = 1'b1;
        proximo = INICIAL;
      end
      default:       proximo = INICIAL;
    endcase
  end

  // The character loaded is the one after the frame now finishing.
  always_comb begin
    sel  = inicio_tx ? 2'd0 : idx + 2'd1;
    dado = ASCII_HASH;
    case (sel)
      2'd0:    dado = ASCII_0 + {3'b000, medida_reg[11:8]};
      2'd1:    dado = ASCII_0 + {3'b000, medida_reg[7:4]};
      2'd2:    dado = ASCII_0 + {3'b000, medida_reg[3:0]};
      default: dado = ASCII_HASH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      echo_m     <= 1'b0;
      echo_s     <= 1'b0;
      mensurar_d <= 1'b0;
      tempo      <= '0;
      cnt_cm     <= '0;
      bcd        <= '0;
      medida_reg <= '0;
      idx        <= '0;
      inicio_tx  <= 1'b0;
    end else begin
      echo_m     <= echo;
      echo_s     <= echo_m;
      mensurar_d <= mensurar;
      tempo      <= (proximo != estado) ? '0 : tempo + 1'b1;
      inicio_tx  <= (estado == ARMAZENA);
      case (estado)
        PREPARACAO: begin
          cnt_cm <= '0;
          bcd    <= '0;
        end
        // The first echo cycle is seen in ESPERA_ECHO, so it is counted there too.
        ESPERA_ECHO, MEDIDA:
          if (echo_s) begin
            if (cnt_cm == CW'(CICLOS_CM - 1)) begin
              cnt_cm <= '0;
              bcd    <= bcd_inc(bcd);
            end else cnt_cm <= cnt_cm + 1'b1;
          end
        TIMEOUT: begin
          bcd    <= BCD_MAX;
          cnt_cm <= '0;
        end
        ARMAZENA: begin
          medida_reg <= (cnt_cm >= CW'((CICLOS_CM + 1) / 2)) ? bcd_inc(bcd) : bcd;
          idx        <= '0;
        end
        TRANSMITE:  if (pronto_tx) idx <= idx + 2'd1;
        default: ;
      endcase
    end
  end

  tx_serial_7e2 #(.CICLOS_BIT(CICLOS_BIT)) u_tx (
    .clock       (clock),
    .reset       (reset),
    .dado        (dado),
    .partida     (partida),
    .saida_serial(saida_serial),
    .pronto_tx   (pronto_tx)
  );

  assign medida0         = hex7seg(medida_reg[3:0]);
  assign medida1         = hex7seg(medida_reg[7:4]);
  assign medida2         = hex7seg(medida_reg[11:8]);
  assign db_estado       = hex7seg(estado);
  assign db_echo         = echo;
  assign db_mensurar     = mensurar;
  assign db_trigger      = trigger;
  assign db_saida_serial = saida_serial;
endmodule

// File: tb/tb_exp4_trena.sv
// Bench for exp4_trena with shortened timing; results are predicted from echo length in cycles.
module tb_exp4_trena;
  localparam int CM = 6, CT = 10, CB = 4, TO = 7000;

  logic clock = 1'b0, reset = 1'b0, mensurar = 1'b0, echo = 1'b0;
  logic trigger, saida_serial, pronto;
  logic [6:0] medida0, medida1, medida2, db_estado;
  logic db_echo, db_mensurar, db_trigger, db_saida_serial;

  always #10 clock = ~clock;

  exp4_trena #(.CLK_HZ(50_000_000), .CICLOS_CM(CM), .CICLOS_TRIGGER(CT),
               .CICLOS_BIT(CB), .CICLOS_TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .mensurar(mensurar), .echo(echo),
    .trigger(trigger), .saida_serial(saida_serial), .pronto(pronto),
    .medida0(medida0), .medida1(medida1), .medida2(medida2), .db_estado(db_estado),
    .db_echo(db_echo), .db_mensurar(db_mensurar), .db_trigger(db_trigger),
    .db_saida_serial(db_saida_serial));

  logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int tests = 0, fails = 0, npronto = 0, mens_left = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock); #1;
    if (pronto === 1'b1) npronto++;
    if (mens_left > 0) begin
      mens_left--;
      if (mens_left == 0) mensurar = 1'b0;
    end
  endtask

  // Round-to-nearest centimetres from echo cycles, 999 on timeout or overflow.
  function automatic int modelo(input int n, input bit sem_eco);
    int v;
    if (sem_eco) return 999;
    v = n / CM + ((2 * (n % CM) >= CM) ? 1 : 0);
    return (v > 999) ? 999 : v;
  endfunction

  task automatic rx_char(input bit seek, output logic [10:0] fr, output bit found);
    int w = 0;
    if (seek) while (saida_serial !== 1'b0 && w < 20000) begin tick(); w++; end
    found = (saida_serial === 1'b0);
    for (int k = 0; k < 11; k++)
      for (int c = 0; c < CB; c++) begin
        if ((k == 0 && c == 0) || (k != 0 && c == CB / 2)) fr[k] = saida_serial;
        tick();
      end
  endtask

  // modo 0: echo of n cycles; 1: no echo; 2: echo stuck high
  task automatic medir(input string tag, input int n, input int modo);
    int w, h, v, d;
    int dig [3];
    logic [6:0] ch;
    logic [10:0] fr;
    bit found;
    v = modelo(n, modo != 0);
    dig[0] = v / 100; dig[1] = (v / 10) % 10; dig[2] = v % 10;
    npronto = 0;
    mensurar = 1'b1; mens_left = 5;
    w = 0;
    while (trigger !== 1'b1 && w < 100) begin tick(); w++; end
    chk({tag, " trig_seen"}, 32'(trigger), 1);
    h = 0;
    while (trigger === 1'b1 && h < 1000) begin tick(); h++; end
    chk({tag, " trig_len"}, h, CT);
    if (modo == 0) begin
      d = 5 + $urandom_range(0, 40);
      mensurar = 1'b1; mens_left = 2;
      for (int i = 0; i < d; i++) tick();
      echo = 1'b1;
      for (int i = 0; i < n; i++) begin
        tick();
        if (n >= 8 && i == n / 2) chk({tag, " st_medida"}, 32'(db_estado), 32'(SEG[4]));
      end
      echo = 1'b0;
    end else if (modo == 1) begin
      for (int i = 0; i < 20; i++) tick();
      chk({tag, " st_espera"}, 32'(db_estado), 32'(SEG[3]));
    end else echo = 1'b1;
    for (int c = 0; c < 4; c++) begin
      ch = (c == 3) ? 7'h23 : 7'h30 + 7'(dig[c]);
      rx_char(c == 0, fr, found);
      if (c == 0) chk({tag, " tx_start"}, 32'(found), 1);
      chk($sformatf("%s frame%0d", tag, c), 32'(fr), 32'({2'b11, ^ch, ch, 1'b0}));
    end
    echo = 1'b0;
    chk({tag, " pronto_at_end"}, 32'(pronto), 1);
    chk({tag, " pronto_count"}, npronto, 1);
    chk({tag, " st_final"}, 32'(db_estado), 32'(SEG[7]));
    tick();
    chk({tag, " pronto_drop"}, 32'(pronto), 0);
    chk({tag, " st_inicial"}, 32'(db_estado), 32'(SEG[0]));
    chk({tag, " disp"}, 32'({medida2, medida1, medida0}),
        32'({SEG[dig[0]], SEG[dig[1]], SEG[dig[2]]}));
    for (int i = 0; i < 5; i++) tick();
  endtask

  initial begin
    int w;
    bit low;
    reset = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    chk("rst trigger", 32'(trigger), 0);
    chk("rst serial", 32'(saida_serial), 1);
    chk("rst pronto", 32'(pronto), 0);
    chk("rst disp", 32'({medida2, medida1, medida0}), 32'({SEG[0], SEG[0], SEG[0]}));
    chk("rst estado", 32'(db_estado), 32'(SEG[0]));
    reset = 1'b1;
    for (int i = 0; i < 5; i++) tick();

    medir("e600", 600, 0);
    medir("e602_trunc", 602, 0);
    medir("e603_round", 603, 0);
    medir("e445", 445, 0);
    medir("e447_round", 447, 0);
    medir("e1", 1, 0);
    medir("e3", 3, 0);
    medir("e5999_sat", 5999, 0);
    for (int r = 0; r < 5; r++) medir($sformatf("rnd%0d", r), $urandom_range(1, 6100), 0);
    medir("no_echo", 0, 1);
    medir("echo_stuck", 0, 2);

    // reset in the middle of a serial frame
    npronto = 0;
    mensurar = 1'b1; mens_left = 5;
    w = 0;
    while (trigger !== 1'b1 && w < 100) begin tick(); w++; end
    while (trigger === 1'b1 && w < 1000) begin tick(); w++; end
    for (int i = 0; i < 10; i++) tick();
    echo = 1'b1;
    for (int i = 0; i < 60; i++) tick();
    echo = 1'b0;
    w = 0;
    while (saida_serial !== 1'b0 && w < 2000) begin tick(); w++; end
    chk("mid tx_start", 32'(saida_serial), 0);
    for (int i = 0; i < 2 * CB + 1; i++) tick();
    reset = 1'b0;
    tick();
    chk("mid serial", 32'(saida_serial), 1);
    chk("mid estado", 32'(db_estado), 32'(SEG[0]));
    chk("mid trigger", 32'(trigger), 0);
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b1;
    low = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (saida_serial !== 1'b1) low = 1'b1;
    end
    chk("mid line_idle", 32'(low), 0);
    chk("mid no_pronto", npronto, 0);
    chk("mid disp", 32'({medida2, medida1, medida0}), 32'({SEG[0], SEG[0], SEG[0]}));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
